// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: latches a payload, strobes the external parity
// calculator during START, then shifts start/data(LSB first)/parity/stop onto TX_OUT.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  par_bit,
  output logic                  par_calc_en,
  output logic [DATA_WIDTH-1:0] par_calc_data,
  output logic                  par_calc_typ,
  output logic                  TX_OUT,
  output logic                  Busy
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          par_en_q;

  assign cnt_nxt = bit_cnt + CW'(1);

  // Outputs are registered: each branch loads the value belonging to the state being entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      par_en_q      <= 1'b0;
      par_calc_data <= '0;
      par_calc_typ  <= 1'b0;
      par_calc_en   <= 1'b0;
      TX_OUT        <= 1'b1;
      Busy          <= 1'b0;
    end else begin
      par_calc_en <= 1'b0;
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
          if (Data_Valid) begin
            par_calc_data <= P_DATA;
            par_calc_typ  <= PAR_TYP;
            par_en_q      <= PAR_EN;
            bit_cnt       <= '0;
            par_calc_en   <= 1'b1;
            TX_OUT        <= 1'b0;
            Busy          <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          TX_OUT <= par_calc_data[0];
          state  <= DATA;
        end
        DATA: begin
          if (bit_cnt == LAST) begin
            bit_cnt <= '0;
            // par_bit has been stable since the first DATA cycle
            if (par_en_q) begin
              TX_OUT <= par_bit;
              state  <= PARITY;
            end else begin
              TX_OUT <= 1'b1;
              state  <= STOP;
            end
          end else begin
            bit_cnt <= cnt_nxt;
            TX_OUT  <= par_calc_data[cnt_nxt];
          end
        end
        PARITY: begin
          TX_OUT <= 1'b1;
          state  <= STOP;
        end
        STOP: begin
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          TX_OUT  <= 1'b1;
          Busy    <= 1'b0;
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl; includes a registered parity calculator
// standing in for the external block.
module tb_uart_tx_ctrl;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       par_bit = 1'b0;
  logic       par_calc_en;
  logic [7:0] par_calc_data;
  logic       par_calc_typ;
  logic       TX_OUT;
  logic       Busy;

  int checks = 0;
  int failures = 0;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .par_bit(par_bit),
    .par_calc_en(par_calc_en), .par_calc_data(par_calc_data),
    .par_calc_typ(par_calc_typ), .TX_OUT(TX_OUT), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // External parity calculator: captures on the strobe, holds otherwise
  always @(posedge CLK)
    if (par_calc_en) par_bit <= (^par_calc_data) ^ par_calc_typ;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] d, input logic pen, input logic typ);
    P_DATA = d;
    PAR_EN = pen;
    PAR_TYP = typ;
    Data_Valid = 1'b1;
    tick();
  endtask

  // Walks a frame already in START; Data_Valid driven with 0x81 during [dv_on, dv_off)
  task automatic body(input string tag, input logic [11:0] exp, input int len,
                      input int dv_on, input int dv_off, input bit end_chk);
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s tx[%0d]", tag, i), TX_OUT, exp[i]);
      chk($sformatf("%s busy[%0d]", tag, i), Busy, 1'b1);
      chk($sformatf("%s en[%0d]", tag, i), par_calc_en, (i == 0));
      if (i == 0) begin
        P_DATA = 8'h00;
        PAR_EN = ~PAR_EN;
        PAR_TYP = ~PAR_TYP;
      end
      if (dv_on < dv_off && i == dv_on) begin
        P_DATA = 8'h81;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
      end
      Data_Valid = (i >= dv_on && i < dv_off);
      tick();
    end
    if (end_chk) begin
      chk({tag, " idle tx"}, TX_OUT, 1'b1);
      chk({tag, " idle busy"}, Busy, 1'b0);
      chk({tag, " idle en"}, par_calc_en, 1'b0);
    end
  endtask

  initial begin
    RST = 1'b1;
    Data_Valid = 1'b1;
    P_DATA = 8'hA5;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst tx", TX_OUT, 1'b1);
      chk("rst busy", Busy, 1'b0);
      chk("rst en", par_calc_en, 1'b0);
      chk("rst data", par_calc_data, 8'h00);
      chk("rst typ", par_calc_typ, 1'b0);
    end

    // First edge with RST low accepts the pending request
    RST = 1'b0;
    tick();
    chk("a5 latched data", par_calc_data, 8'hA5);
    chk("a5 latched typ", par_calc_typ, 1'b0);
    body("even_a5", {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 0, 0, 1'b1);
    tick();

    start_frame(8'h07, 1'b1, 1'b1);
    chk("07 latched typ", par_calc_typ, 1'b1);
    body("odd_07", {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 0, 0, 1'b1);

    start_frame(8'hFF, 1'b0, 1'b0);
    body("nopar_ff", {2'b00, 1'b1, 8'hFF, 1'b0}, 10, 0, 0, 1'b1);

    start_frame(8'h3C, 1'b1, 1'b0);
    body("busy_drop", {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 2, 5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no second frame busy", Busy, 1'b0);
      chk("no second frame tx", TX_OUT, 1'b1);
    end

    // Held request: exactly one IDLE cycle, then a 0x81 frame
    start_frame(8'h3C, 1'b1, 1'b0);
    body("busy_hold", {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 2, 100, 1'b1);
    tick();
    chk("b2b latched data", par_calc_data, 8'h81);
    body("b2b_81", {1'b0, 1'b1, 1'b0, 8'h81, 1'b0}, 11, 0, 0, 1'b1);

    // Abort during data bit 4 (odd parity captured), then retry with even parity
    start_frame(8'h55, 1'b1, 1'b1);
    body("abort_55", {1'b0, 1'b1, 1'b1, 8'h55, 1'b0}, 5, 0, 0, 1'b0);
    chk("abort bit4 tx", TX_OUT, 1'b1);
    chk("abort bit4 busy", Busy, 1'b1);
    RST = 1'b1;
    tick();
    chk("abort rst tx", TX_OUT, 1'b1);
    chk("abort rst busy", Busy, 1'b0);
    chk("abort rst en", par_calc_en, 1'b0);
    RST = 1'b0;
    tick();
    chk("abort stays idle", Busy, 1'b0);
    start_frame(8'h55, 1'b1, 1'b0);
    body("fresh_55", {1'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11, 0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
